fetch_ctrl: RTL

- Instruction-fetch sequencer that owns the architectural PC register and drives the instruction-memory request port.
- Arbitrates PC redirect sources (trap, mret, branch/jump next-PC from the PC mux) and sequences a single-outstanding fetch to imem.
- Presents fetched instructions to decode with a valid/ready handshake.
- Sits between the imem interface and the decode stage; the PC mux result feeds in as redir_pc.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the architectural PC, issues single-outstanding imem reads, hands words to decode.
// Latency: grant at cycle t, rvalid at t+k gives if_valid at t+k+1; at least 3 cycles per instruction.
// Backpressure: if_ready=0 holds if_valid/if_inst/if_pc stable in OUT and no new request is issued.
//
// Ports:
//   clk, rst_n                      core clock, async active-low reset
//   fetch_en                        permits new fetches (sampled in IDLE and when leaving OUT)
//   imem_req/addr, imem_gnt         request channel to instruction memory
//   imem_rvalid/rdata               response channel from instruction memory
//   if_valid/inst/pc, if_ready      valid/ready hand-off to decode
//   redir_valid/pc, trap/mtvec,     redirect sources, priority trap > mret > redir_valid
//   mret/mepc
module fetch_ctrl #(
  parameter int unsigned        XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            trap,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  logic            redirect;
  logic [XLEN-1:0] redir_sel;
  logic [XLEN-1:0] redir_tgt;

  // Redirect arbitration; targets are forced word aligned so pc_q never
  // holds an unaligned address.
  always_comb begin
    redirect  = trap | mret | redir_valid;
    redir_sel = trap ? mtvec : (mret ? mepc : redir_pc);
    redir_tgt = redir_sel & {{(XLEN-2){1'b1}}, 2'b00};
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redir_tgt;
        if (fetch_en) state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) pc_d = redir_tgt;
        if (imem_gnt) begin
          state_d = S_WAIT;
          // The granted request targets the old PC; its response must be dropped.
          if (redirect) kill_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          // Every response ends the outstanding request, so kill always clears here.
          kill_d  = 1'b0;
          state_d = S_REQ;
          if (redirect) begin
            pc_d = redir_tgt;
          end else if (!kill_q) begin
            state_d    = S_OUT;
            if_valid_d = 1'b1;
            if_inst_d  = imem_rdata;
            if_pc_d    = pc_q;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = redir_tgt;
        end
      end

      S_OUT: begin
        if (redirect || if_ready) begin
          pc_d       = redirect ? redir_tgt : (pc_q + XLEN'(4));
          if_valid_d = 1'b0;
          state_d    = fetch_en ? S_REQ : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // imem_req is a pure decode of the state register, so if_ready cannot reach it combinationally.
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;

endmodule
